// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - symbolic MIPS instruction encoder, FIFO and instruction-memory writer
//
// Purpose: encodes symbolic instructions into 32-bit MIPS words, queues them
// in a small FIFO and writes them sequentially into instruction memory
// during a load session before the core is released from reset.
//
// Ports:
//   i_clk, i_reset       clock; asynchronous active-high reset
//   i_start              one-cycle pulse starting a load session
//   i_in_valid/o_in_ready handshake for one symbolic instruction
//   i_in_mnem            mnemonic code (0..17 legal, 18..31 illegal)
//   i_in_rs/rt/rd/shamt  register and shift fields
//   i_in_imm             I-type immediate
//   i_in_target          J-type word target
//   i_in_last            final instruction of the session
//   o_mem_we/addr/wdata  instruction-memory write port
//   o_done               session complete, held until next start
//   o_err                sticky illegal-mnemonic flag for this session
//   o_word_count         words written this session

module instr_mem_loader #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h0040_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [4:0]        i_in_mnem,
  input  logic [4:0]        i_in_rs,
  input  logic [4:0]        i_in_rt,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_shamt,
  input  logic [15:0]       i_in_imm,
  input  logic [25:0]       i_in_target,
  input  logic              i_in_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_word_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [32:0]        r_fifo [DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;

  logic [ADDR_W-1:0]  r_addr_cnt;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_done;
  logic               r_err;
  logic [15:0]        r_word_count;
  logic               r_last_acc;

  logic [31:0]        w_word;
  logic               w_illegal;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_start_sess;
  logic [32:0]        w_head;

  // Inverse of the control decoder: mnemonic -> opcode/funct with the
  // unused fields of each form forced to zero.
  always_comb begin
    w_word    = 32'h0000_0000;
    w_illegal = 1'b0;
    case (i_in_mnem)
      5'd0:  w_word = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h20};
      5'd1:  w_word = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h22};
      5'd2:  w_word = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h24};
      5'd3:  w_word = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h25};
      5'd4:  w_word = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'd0, 6'h27};
      5'd5:  w_word = {6'h00, 5'd0, i_in_rt, i_in_rd, i_in_shamt, 6'h00};
      5'd6:  w_word = {6'h00, 5'd0, i_in_rt, i_in_rd, i_in_shamt, 6'h02};
      5'd7:  w_word = {6'h00, i_in_rs, 15'd0, 6'h08};
      5'd8:  w_word = {6'h08, i_in_rs, i_in_rt, i_in_imm};
      5'd9:  w_word = {6'h0d, i_in_rs, i_in_rt, i_in_imm};
      5'd10: w_word = {6'h0c, i_in_rs, i_in_rt, i_in_imm};
      5'd11: w_word = {6'h0f, 5'd0, i_in_rt, i_in_imm};
      5'd12: w_word = {6'h04, i_in_rs, i_in_rt, i_in_imm};
      5'd13: w_word = {6'h05, i_in_rs, i_in_rt, i_in_imm};
      5'd14: w_word = {6'h23, i_in_rs, i_in_rt, i_in_imm};
      5'd15: w_word = {6'h2b, i_in_rs, i_in_rt, i_in_imm};
      5'd16: w_word = {6'h02, i_in_target};
      5'd17: w_word = {6'h03, i_in_target};
      default: w_illegal = 1'b1;
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head  = r_fifo[r_rd_ptr[PTR_W-1:0]];

  // start only has effect outside LOAD.
  assign w_start_sess = i_start && (r_state != S_LOAD);
  assign o_in_ready   = (r_state == S_LOAD) && !w_full && !r_last_acc;
  assign w_push       = i_in_valid && o_in_ready;
  assign w_pop        = (r_state == S_LOAD) && !w_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_pop && w_head[32]) w_state_nxt = S_DONE;
      S_DONE:  if (i_start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[PTR_W-1:0]] <= {i_in_last, w_word};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_addr_cnt   <= BASE_ADDR;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= 32'h0000_0000;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= 16'd0;
      r_last_acc   <= 1'b0;
    end else begin
      r_mem_we <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_start_sess) begin
        // Push/pop cannot coincide with a session start (both need LOAD).
        r_addr_cnt   <= BASE_ADDR;
        r_word_count <= 16'd0;
        r_err        <= 1'b0;
        r_done       <= 1'b0;
        r_last_acc   <= 1'b0;
      end else begin
        if (w_push) begin
          if (w_illegal) r_err      <= 1'b1;
          if (i_in_last) r_last_acc <= 1'b1;
        end
        if (w_pop) begin
          r_mem_addr   <= r_addr_cnt;
          r_mem_wdata  <= w_head[31:0];
          r_addr_cnt   <= r_addr_cnt + ADDR_W'(4);
          r_word_count <= r_word_count + 16'd1;
          if (w_head[32]) r_done <= 1'b1;
        end
      end
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader

module tb_instr_mem_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  localparam logic [5:0] FN [0:7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
  localparam logic [5:0] OP [0:9] = '{6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h02, 6'h03};

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [4:0]  i_in_mnem;
  logic [4:0]  i_in_rs;
  logic [4:0]  i_in_rt;
  logic [4:0]  i_in_rd;
  logic [4:0]  i_in_shamt;
  logic [15:0] i_in_imm;
  logic [25:0] i_in_target;
  logic        i_in_last;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_word_count;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_mnem(i_in_mnem), .i_in_rs(i_in_rs), .i_in_rt(i_in_rt),
    .i_in_rd(i_in_rd), .i_in_shamt(i_in_shamt), .i_in_imm(i_in_imm),
    .i_in_target(i_in_target), .i_in_last(i_in_last),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_done(o_done), .o_err(o_err), .o_word_count(o_word_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_wr  = 0;
  int          max_out = 0;
  logic [31:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] m, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [15:0] imm,
                                      input logic [25:0] tg);
    int  mi;
    bit  is_shift;
    mi = int'(m);
    is_shift = (mi == 5) || (mi == 6);
    if (mi == 7)
      return {6'h00, rs, 15'd0, FN[7]};
    if (mi < 7)
      return {6'h00, is_shift ? 5'd0 : rs, rt, rd, is_shift ? sh : 5'd0, FN[mi]};
    if (mi < 16)
      return {OP[mi-8], (mi == 11) ? 5'd0 : rs, rt, imm};
    if (mi < 18)
      return {OP[mi-8], tg};
    return 32'h0000_0000;
  endfunction

  // Every write must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      n_wr++;
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", o_mem_addr, mon_e.addr);
        chk("wr_data", o_mem_wdata, mon_e.data);
      end
    end
  end

  task automatic do_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    exp_addr = BASE;
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tg, input logic last, input logic [31:0] word);
    int c;
    i_in_mnem = m; i_in_rs = rs; i_in_rt = rt; i_in_rd = rd; i_in_shamt = sh;
    i_in_imm = imm; i_in_target = tg; i_in_last = last; i_in_valid = 1'b1;
    c = 0;
    while (o_in_ready !== 1'b1 && c < 50) begin
      @(negedge i_clk);
      c++;
    end
    chk("in_ready", 32'(o_in_ready), 32'd1);
    if ((n_acc - n_wr + 1) > max_out) max_out = n_acc - n_wr + 1;
    sb.push_back('{addr: exp_addr, data: word});
    exp_addr = exp_addr + 32'd4;
    n_acc++;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (o_done !== 1'b1 && c < 100) begin
      @(negedge i_clk);
      c++;
    end
    chk("done", 32'(o_done), 32'd1);
    @(negedge i_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [4:0]  m, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tg;

    i_reset = 1'b1; i_start = 1'b0; i_in_valid = 1'b0; i_in_mnem = '0;
    i_in_rs = '0; i_in_rt = '0; i_in_rd = '0; i_in_shamt = '0;
    i_in_imm = '0; i_in_target = '0; i_in_last = 1'b0;
    exp_addr = BASE;
    #12;
    chk("rst_in_ready",   32'(o_in_ready),   32'd0);
    chk("rst_mem_we",     32'(o_mem_we),     32'd0);
    chk("rst_mem_addr",   o_mem_addr,        BASE);
    chk("rst_mem_wdata",  o_mem_wdata,       32'd0);
    chk("rst_done",       32'(o_done),       32'd0);
    chk("rst_err",        32'(o_err),        32'd0);
    chk("rst_word_count", 32'(o_word_count), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Single ADDI.
    do_start();
    send(5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b1, 32'h2008_0005);
    wait_done();
    chk("single_wc",    32'(o_word_count), 32'd1);
    chk("single_ready", 32'(o_in_ready),   32'd0);
    repeat (3) @(negedge i_clk);

    // Field forcing.
    do_start();
    send(5'd0,  5'd8, 5'd9, 5'd10, 5'd7, 16'h0000, 26'd0,        1'b0, 32'h0109_5020);
    send(5'd11, 5'd3, 5'd1, 5'd0,  5'd0, 16'h1001, 26'd0,        1'b0, 32'h3C01_1001);
    send(5'd16, 5'd0, 5'd0, 5'd0,  5'd0, 16'h0000, 26'h010_0000, 1'b1, 32'h0810_0000);
    wait_done();
    chk("force_wc", 32'(o_word_count), 32'd3);

    // Restart from DONE, then 10 back-to-back words with a start in LOAD.
    do_start();
    chk("restart_done", 32'(o_done),       32'd0);
    chk("restart_err",  32'(o_err),        32'd0);
    chk("restart_wc",   32'(o_word_count), 32'd0);
    max_out = 0;
    for (int i = 0; i < 10; i++) begin
      m  = 5'(i % 18);
      rs = 5'($urandom_range(31)); rt = 5'($urandom_range(31));
      rd = 5'($urandom_range(31)); sh = 5'($urandom_range(31));
      imm = 16'($urandom); tg = 26'($urandom);
      if (i == 4) i_start = 1'b1;
      send(m, rs, rt, rd, sh, imm, tg, (i == 9), enc(m, rs, rt, rd, sh, imm, tg));
      i_start = 1'b0;
    end
    wait_done();
    chk("burst_wc", 32'(o_word_count), 32'd10);
    chk("burst_max_outstanding", 32'(max_out <= DEPTH), 32'd1);

    // Illegal mnemonic in the middle of a session.
    do_start();
    send(5'd0,  5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'd0, 1'b0, enc(5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'd0));
    chk("pre_illegal_err", 32'(o_err), 32'd0);
    send(5'd25, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FF_FFFF, 1'b0, 32'h0000_0000);
    chk("illegal_err_rise", 32'(o_err), 32'd1);
    send(5'd1,  5'd5, 5'd6, 5'd7, 5'd3, 16'h0, 26'd0, 1'b1, enc(5'd1, 5'd5, 5'd6, 5'd7, 5'd3, 16'h0, 26'd0));
    wait_done();
    chk("illegal_err_held", 32'(o_err),        32'd1);
    chk("illegal_wc",       32'(o_word_count), 32'd3);

    // Reset in the middle of a session.
    do_start();
    chk("start_clears_err", 32'(o_err), 32'd0);
    send(5'd9,  5'd1, 5'd2, 5'd0, 5'd0, 16'h00F0, 26'd0, 1'b0, 32'h3422_00F0);
    send(5'd10, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0F0F, 26'd0, 1'b0, 32'h3064_0F0F);
    send(5'd12, 5'd5, 5'd6, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b0, 32'h10A6_FFFE);
    #1;
    i_reset = 1'b1;
    #1;
    chk("midrst_mem_we",   32'(o_mem_we),   32'd0);
    chk("midrst_in_ready", 32'(o_in_ready), 32'd0);
    chk("midrst_mem_addr", o_mem_addr,      BASE);
    sb.delete();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    do_start();
    send(5'd14, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 32'h8FA8_0004);
    wait_done();
    chk("postrst_wc", 32'(o_word_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
